// File: rtl/layer_stack_compositor_pkg.sv
// Shared types and constants for the layer stack compositor: palette colour width,
// the "no colour" code, winning-source codes and the palette-to-RGB lookup.
package layer_stack_compositor_pkg;

  localparam int COLOR_WIDTH = 4;

  localparam logic [COLOR_WIDTH-1:0] COLOR_NONE  = 4'd0;
  localparam logic [COLOR_WIDTH-1:0] COLOR_RED   = 4'd1;
  localparam logic [COLOR_WIDTH-1:0] COLOR_GREEN = 4'd2;
  localparam logic [COLOR_WIDTH-1:0] COLOR_BLUE  = 4'd3;

  localparam int SRC_CAMERA     = 0;
  localparam int SRC_CURSOR     = 1;
  localparam int SRC_LAYER_BASE = 2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  function automatic rgb_t color_to_rgb(input logic [COLOR_WIDTH-1:0] c);
    rgb_t v;
    case (c)
      4'd1:    v = 24'hff0000;
      4'd2:    v = 24'h00ff00;
      4'd3:    v = 24'h0000ff;
      4'd4:    v = 24'hffff00;
      4'd5:    v = 24'h00ffff;
      4'd6:    v = 24'hff00ff;
      4'd7:    v = 24'hffffff;
      4'd8:    v = 24'h808080;
      4'd9:    v = 24'h800000;
      4'd10:   v = 24'h008000;
      4'd11:   v = 24'h000080;
      4'd12:   v = 24'h808000;
      4'd13:   v = 24'h008080;
      4'd14:   v = 24'h800080;
      4'd15:   v = 24'hc0c0c0;
      default: v = 24'h000000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/layer_stack_compositor_order_table.sv
// Z-order permutation table: pending order updated by swap-on-write, copied to the
// active order on frame_start (including a same-cycle write).
module layer_order_table #(
  parameter  int NUM_LAYERS = 4,
  localparam int LW         = $clog2(NUM_LAYERS)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           frame_start,
  input  logic                           order_wr,
  input  logic [LW-1:0]                  order_slot,
  input  logic [LW-1:0]                  order_id,
  output logic [NUM_LAYERS-1:0][LW-1:0]  active_order_o
);

  logic [NUM_LAYERS-1:0][LW-1:0] pend_q, pend_d, act_q;

  // Writing an id moves it to the target slot and pushes the displaced id into
  // the slot it came from, so the table never stops being a permutation.
  always_comb begin
    pend_d = pend_q;
    if (order_wr) begin
      for (int t = 0; t < NUM_LAYERS; t++) begin
        if (pend_q[t] == order_id) pend_d[t] = pend_q[order_slot];
      end
      pend_d[order_slot] = order_id;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        pend_q[i] <= LW'(i);
        act_q[i]  <= LW'(i);
      end
    end else begin
      pend_q <= pend_d;
      if (frame_start) act_q <= pend_d;
    end
  end

  assign active_order_o = act_q;

endmodule

// File: rtl/layer_stack_compositor.sv
// Composites camera, cursor and NUM_LAYERS palette layers into one RGB pixel.
// Fixed 3-cycle latency, no backpressure; config is double-buffered and commits on frame_start.
module layer_stack_compositor
  import layer_stack_compositor_pkg::*;
#(
  parameter  int WIDTH      = 640,
  parameter  int HEIGHT     = 480,
  parameter  int NUM_LAYERS = 4,
  localparam int LW         = $clog2(NUM_LAYERS),
  localparam int XW         = $clog2(WIDTH),
  localparam int YW         = $clog2(HEIGHT),
  localparam int SW         = LW + 2
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              frame_start,
  input  logic                              order_wr,
  input  logic [LW-1:0]                     order_slot,
  input  logic [LW-1:0]                     order_id,
  input  logic [NUM_LAYERS-1:0]             visible_mask,
  input  logic                              cursor_visible,
  input  logic                              in_valid,
  input  logic [XW-1:0]                     in_x,
  input  logic [YW-1:0]                     in_y,
  input  logic [NUM_LAYERS*COLOR_WIDTH-1:0] layer_colors,
  input  logic [COLOR_WIDTH-1:0]            cursor_color,
  input  logic [7:0]                        camera_r,
  input  logic [7:0]                        camera_g,
  input  logic [7:0]                        camera_b,
  output logic                              out_valid,
  output logic [XW-1:0]                     out_x,
  output logic [YW-1:0]                     out_y,
  output logic [7:0]                        out_r,
  output logic [7:0]                        out_g,
  output logic [7:0]                        out_b,
  output logic [SW-1:0]                     out_src
);

  logic [NUM_LAYERS-1:0][LW-1:0] act_order;

  layer_order_table #(.NUM_LAYERS(NUM_LAYERS)) u_order (
    .clk            (clk),
    .reset_n        (reset_n),
    .frame_start    (frame_start),
    .order_wr       (order_wr),
    .order_slot     (order_slot),
    .order_id       (order_id),
    .active_order_o (act_order)
  );

  // Visibility shadows: pending sampled every cycle, active loaded on commit.
  logic [NUM_LAYERS-1:0] pvis_q, avis_q;
  logic                  pcur_q, acur_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pvis_q <= '0;
      avis_q <= '0;
      pcur_q <= 1'b0;
      acur_q <= 1'b0;
    end else begin
      pvis_q <= visible_mask;
      pcur_q <= cursor_visible;
      if (frame_start) begin
        avis_q <= pvis_q;
        acur_q <= pcur_q;
      end
    end
  end

  // S1: gate each slot's colour by the active config and capture the slot ids,
  // so in-flight pixels are immune to later commits.
  logic [NUM_LAYERS-1:0][COLOR_WIDTH-1:0] s1_col_d, s1_col_q;
  logic [NUM_LAYERS-1:0][LW-1:0]          s1_id_q;
  logic [COLOR_WIDTH-1:0]                 s1_cur_q;
  logic                                   s1_vld_q;
  logic [XW-1:0]                          s1_x_q;
  logic [YW-1:0]                          s1_y_q;
  rgb_t                                   s1_cam_q;

  always_comb begin
    s1_col_d = '0;
    for (int s = 0; s < NUM_LAYERS; s++) begin
      s1_col_d[s] = avis_q[act_order[s]]
                  ? layer_colors[int'(act_order[s])*COLOR_WIDTH +: COLOR_WIDTH]
                  : COLOR_NONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q <= 1'b0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
      s1_cam_q <= '0;
      s1_cur_q <= COLOR_NONE;
      s1_col_q <= '0;
      s1_id_q  <= '0;
    end else begin
      s1_vld_q <= in_valid;
      s1_x_q   <= in_x;
      s1_y_q   <= in_y;
      s1_cam_q <= {camera_r, camera_g, camera_b};
      s1_cur_q <= acur_q ? cursor_color : COLOR_NONE;
      s1_col_q <= s1_col_d;
      s1_id_q  <= act_order;
    end
  end

  // S2: cursor beats every layer; otherwise the lowest (topmost) non-empty slot wins.
  logic [COLOR_WIDTH-1:0] s2_col_d, s2_col_q;
  logic [SW-1:0]          s2_src_d, s2_src_q;
  logic                   s2_vld_q;
  logic [XW-1:0]          s2_x_q;
  logic [YW-1:0]          s2_y_q;
  rgb_t                   s2_cam_q;

  always_comb begin
    s2_col_d = COLOR_NONE;
    s2_src_d = SW'(SRC_CAMERA);
    for (int s = NUM_LAYERS - 1; s >= 0; s--) begin
      if (s1_col_q[s] != COLOR_NONE) begin
        s2_col_d = s1_col_q[s];
        s2_src_d = SW'(SRC_LAYER_BASE) + SW'(s1_id_q[s]);
      end
    end
    if (s1_cur_q != COLOR_NONE) begin
      s2_col_d = s1_cur_q;
      s2_src_d = SW'(SRC_CURSOR);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_vld_q <= 1'b0;
      s2_x_q   <= '0;
      s2_y_q   <= '0;
      s2_cam_q <= '0;
      s2_col_q <= COLOR_NONE;
      s2_src_q <= '0;
    end else begin
      s2_vld_q <= s1_vld_q;
      s2_x_q   <= s1_x_q;
      s2_y_q   <= s1_y_q;
      s2_cam_q <= s1_cam_q;
      s2_col_q <= s2_col_d;
      s2_src_q <= s2_src_d;
    end
  end

  // S3: palette lookup; output data registers hold through bubbles.
  rgb_t s3_rgb_d;

  always_comb begin
    s3_rgb_d = (s2_src_q == SW'(SRC_CAMERA)) ? s2_cam_q : color_to_rgb(s2_col_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_src   <= '0;
    end else begin
      out_valid <= s2_vld_q;
      if (s2_vld_q) begin
        out_x   <= s2_x_q;
        out_y   <= s2_y_q;
        out_r   <= s3_rgb_d.r;
        out_g   <= s3_rgb_d.g;
        out_b   <= s3_rgb_d.b;
        out_src <= s2_src_q;
      end
    end
  end

endmodule

// File: tb/tb_layer_stack_compositor.sv
// Randomized and directed bench for layer_stack_compositor against a behavioural
// model of slot priority, double-buffered config and a 3-deep output delay.
module tb_layer_stack_compositor;
  import layer_stack_compositor_pkg::*;

  localparam int NL = 4;
  localparam int CW = COLOR_WIDTH;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          order_wr = 1'b0;
  logic [1:0]    order_slot = '0;
  logic [1:0]    order_id = '0;
  logic [NL-1:0] visible_mask = '0;
  logic          cursor_visible = 1'b0;
  logic          in_valid = 1'b0;
  logic [9:0]    in_x = '0;
  logic [8:0]    in_y = '0;
  logic [NL*CW-1:0] layer_colors = '0;
  logic [CW-1:0] cursor_color = '0;
  logic [7:0]    camera_r = '0, camera_g = '0, camera_b = '0;
  logic          out_valid;
  logic [9:0]    out_x;
  logic [8:0]    out_y;
  logic [7:0]    out_r, out_g, out_b;
  logic [3:0]    out_src;

  layer_stack_compositor #(.WIDTH(640), .HEIGHT(480), .NUM_LAYERS(NL)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .order_wr(order_wr), .order_slot(order_slot), .order_id(order_id),
    .visible_mask(visible_mask), .cursor_visible(cursor_visible),
    .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .layer_colors(layer_colors), .cursor_color(cursor_color),
    .camera_r(camera_r), .camera_g(camera_g), .camera_b(camera_b),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_src(out_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          vld;
    int unsigned x, y, rgb, src;
  } pix_t;

  int   checks = 0;
  int   failures = 0;
  logic [23:0] pal [16];

  int   m_pend [NL];
  int   m_act  [NL];
  bit [NL-1:0] m_pvis, m_avis;
  bit   m_pcur, m_acur;
  pix_t p1, p2, mout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lcol(input int id);
    logic [NL*CW-1:0] lc;
    lc = layer_colors;
    return int'(lc[id*CW +: CW]);
  endfunction

  task automatic model_reset();
    pix_t z;
    z = '{vld: 0, x: 0, y: 0, rgb: 0, src: 0};
    p1 = z; p2 = z; mout = z;
    for (int i = 0; i < NL; i++) begin m_pend[i] = i; m_act[i] = i; end
    m_pvis = '0; m_avis = '0; m_pcur = 0; m_acur = 0;
  endtask

  // Expected pixel from the current inputs under the model's active config.
  function automatic pix_t model_pixel();
    pix_t e;
    e.vld = in_valid; e.x = in_x; e.y = in_y;
    e.src = 0; e.rgb = {camera_r, camera_g, camera_b};
    if (m_acur && cursor_color != 0) begin
      e.src = 1; e.rgb = pal[cursor_color];
    end else begin
      for (int s = 0; s < NL; s++) begin
        if (m_avis[m_act[s]] && lcol(m_act[s]) != 0) begin
          e.src = 2 + m_act[s]; e.rgb = pal[lcol(m_act[s])];
          break;
        end
      end
    end
    return e;
  endfunction

  task automatic step();
    pix_t e, emitted;
    int   t, old;
    e = model_pixel();
    if (order_wr) begin
      t = 0;
      for (int i = 0; i < NL; i++) if (m_pend[i] == int'(order_id)) t = i;
      old = m_pend[order_slot];
      m_pend[order_slot] = order_id;
      m_pend[t] = old;
    end
    if (frame_start) begin
      m_act = m_pend; m_avis = m_pvis; m_acur = m_pcur;
    end
    m_pvis = visible_mask; m_pcur = cursor_visible;
    @(posedge clk);
    emitted = p2; p2 = p1; p1 = e;
    mout.vld = emitted.vld;
    if (emitted.vld) mout = emitted;
    #1;
    chk("out_valid", 32'(out_valid), 32'(mout.vld));
    chk("out_x", 32'(out_x), mout.x);
    chk("out_y", 32'(out_y), mout.y);
    chk("out_rgb", {8'h0, out_r, out_g, out_b}, mout.rgb);
    chk("out_src", 32'(out_src), mout.src);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_xy", {13'h0, out_x, out_y}, 0);
    chk("rst_rgb", {8'h0, out_r, out_g, out_b}, 0);
    chk("rst_src", 32'(out_src), 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_layer(input int k, input logic [CW-1:0] c);
    layer_colors[k*CW +: CW] = c;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_pend(input string tag, input int a, input int b, input int c, input int d);
    int exp [NL];
    bit [NL-1:0] seen;
    exp[0] = a; exp[1] = b; exp[2] = c; exp[3] = d;
    seen = '0;
    for (int s = 0; s < NL; s++) begin
      chk(tag, 32'(dut.u_order.pend_q[s]), exp[s]);
      chk("pend_model", 32'(m_pend[s]), exp[s]);
      seen[dut.u_order.pend_q[s]] = 1'b1;
    end
    chk("pend_perm", 32'(seen), 32'hf);
  endtask

  initial begin
    pal = '{24'h000000, 24'hff0000, 24'h00ff00, 24'h0000ff,
            24'hffff00, 24'h00ffff, 24'hff00ff, 24'hffffff,
            24'h808080, 24'h800000, 24'h008000, 24'h000080,
            24'h808000, 24'h008080, 24'h800080, 24'hc0c0c0};
    model_reset();
    #2;
    chk("init_valid", 32'(out_valid), 0);
    chk("init_rgb", {8'h0, out_r, out_g, out_b}, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Camera passthrough, first valid exactly 3 cycles after in_valid.
    camera_r = 8'd10; camera_g = 8'd20; camera_b = 8'd30;
    in_valid = 1'b1; in_x = 10'd5; in_y = 9'd7;
    step(); chk("lat_c1", 32'(out_valid), 0);
    step(); chk("lat_c2", 32'(out_valid), 0);
    step(); chk("lat_c3", 32'(out_valid), 1);
    chk("cam_rgb", {8'h0, out_r, out_g, out_b}, 32'h0a141e);
    chk("cam_src", 32'(out_src), 0);

    // Layer visibility and z-order commit.
    visible_mask = 4'b0011; set_layer(0, COLOR_RED); set_layer(1, COLOR_BLUE);
    step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    run(4);
    chk("red_rgb", {8'h0, out_r, out_g, out_b}, 32'hff0000);
    chk("red_src", 32'(out_src), 2);
    order_wr = 1'b1; order_slot = 2'd0; order_id = 2'd1; frame_start = 1'b1;
    step(); order_wr = 1'b0; frame_start = 1'b0;
    run(4);
    chk("blue_rgb", {8'h0, out_r, out_g, out_b}, 32'h0000ff);
    chk("blue_src", 32'(out_src), 3);

    // Commit timing: mask change is invisible until frame_start.
    visible_mask = 4'b0000;
    for (int i = 0; i < 100; i++) begin
      step();
      chk("hold_blue", {8'h0, out_r, out_g, out_b}, 32'h0000ff);
    end
    frame_start = 1'b1; step(); frame_start = 1'b0;
    step(); step();
    chk("commit_old", {8'h0, out_r, out_g, out_b}, 32'h0000ff);
    step();
    chk("commit_new", {8'h0, out_r, out_g, out_b}, 32'h0a141e);
    chk("commit_src", 32'(out_src), 0);

    // Cursor priority over all visible layers.
    visible_mask = 4'b1111; cursor_visible = 1'b1; cursor_color = COLOR_GREEN;
    set_layer(2, 4'd4); set_layer(3, 4'd5);
    step(); frame_start = 1'b1; step(); frame_start = 1'b0;
    run(4);
    chk("cur_rgb", {8'h0, out_r, out_g, out_b}, 32'h00ff00);
    chk("cur_src", 32'(out_src), 1);
    cursor_color = COLOR_NONE;
    run(4);
    chk("top_rgb", {8'h0, out_r, out_g, out_b}, 32'h0000ff);
    chk("top_src", 32'(out_src), 3);

    // Swap semantics on the pending table from reset order.
    do_reset();
    in_valid = 1'b0;
    order_wr = 1'b1; order_slot = 2'd0; order_id = 2'd3; step();
    chk_pend("swap1", 3, 1, 2, 0);
    order_slot = 2'd2; order_id = 2'd3; step();
    chk_pend("swap2", 2, 1, 3, 0);
    order_slot = 2'd1; order_id = 2'd1; step();
    chk_pend("swap_same", 2, 1, 3, 0);
    order_wr = 1'b0;

    // Mid-stream reset with bubbles, then the same bubble pattern after release.
    in_valid = 1'b1; step(); in_valid = 1'b0; step(); in_valid = 1'b1; step();
    do_reset();
    in_valid = 1'b1; step(); in_valid = 1'b0; step(); in_valid = 1'b1; step();
    chk("bub_a", 32'(out_valid), 1);
    in_valid = 1'b0; step(); chk("bub_b", 32'(out_valid), 0);
    step(); chk("bub_c", 32'(out_valid), 1);
    step(); chk("bub_d", 32'(out_valid), 0);

    // Randomized traffic with config churn and one reset.
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_x = 10'($urandom_range(0, 639));
      in_y = 9'($urandom_range(0, 479));
      camera_r = 8'($urandom); camera_g = 8'($urandom); camera_b = 8'($urandom);
      for (int k = 0; k < NL; k++)
        set_layer(k, ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
      cursor_color = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      order_wr = ($urandom_range(0, 3) == 0);
      order_slot = 2'($urandom_range(0, 3));
      order_id = 2'($urandom_range(0, 3));
      frame_start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) visible_mask = 4'($urandom);
      if ($urandom_range(0, 15) == 0) cursor_visible = ~cursor_visible;
      if (i == 700) do_reset();
      step();
    end
    order_wr = 1'b0; frame_start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
